// File: rtl/deser_ctrl.sv
// deser_ctrl: serial-to-parallel word receiver.
// Shifts data_in MSB-first on each bit_tick after a frame_start request,
// presents the assembled word with a valid/ready handshake, flags lost ticks
// while a word is held (sticky overrun) and aborts a frame whose ticks stop
// (one-cycle timeout pulse).
// Optional feature: define DESER_PARITY_EN to receive one trailing even-parity
// bit per word and report it on parity_err alongside data_valid.
module deser_ctrl #(
  parameter int WORD_W      = 8,   // bits per word, 2..16
  parameter int TIMEOUT_CYC = 40   // max cycles between ticks while shifting, >= 2
) (
  input  logic              clock_1M,
  input  logic              reset,        // asynchronous, active-low
  input  logic              data_in,
  input  logic              bit_tick,
  input  logic              frame_start,
  input  logic              out_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              ack,
  output logic              busy,
  output logic              overrun,
  output logic              timeout
`ifdef DESER_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  // The timer reads 0 in the first cycle after a tick (or frame_start), so the
  // frame is abandoned on the edge that ends the cycle reading TIMEOUT_CYC-2;
  // the pulse then appears TIMEOUT_CYC cycles after the last tick.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 2);

`ifdef DESER_PARITY_EN
  // The full word must be kept until the parity bit arrives.
  localparam int SR_W = WORD_W;
`else
  // The final bit goes straight into data_out, so one bit less is stored.
  localparam int SR_W = WORD_W - 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_HOLD   = 2'd2
`ifdef DESER_PARITY_EN
    ,
    ST_PARITY = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [SR_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              tmr_expired;
`ifdef DESER_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  assign tmr_expired = (tmr_q == TMR_LAST);

  // Next-state and datapath updates for the receive FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tmr_d        = tmr_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    timeout_d    = 1'b0;
`ifdef DESER_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A tick coinciding with frame_start is deliberately not sampled.
        if (frame_start) begin
          bit_cnt_d = '0;
          tmr_d     = '0;
          shreg_d   = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_tick) begin
          shreg_d   = SR_W'({shreg_q, data_in});
          bit_cnt_d = bit_cnt_q + 1'b1;
          tmr_d     = '0;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef DESER_PARITY_EN
            state_d = ST_PARITY;
`else
            data_out_d   = {shreg_q, data_in};
            data_valid_d = 1'b1;
            state_d      = ST_HOLD;
`endif
          end
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`ifdef DESER_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          data_out_d   = shreg_q;
          parity_err_d = ^{shreg_q, data_in};
          data_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`endif
      ST_HOLD: begin
        if (bit_tick) overrun_d = 1'b1;
        if (out_ready) begin
          data_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock_1M or negedge reset) begin
    if (!reset) begin
      // NOTE: the shift register and data_out are cleared too, because the
      // outputs must read 0 in reset rather than stale data.
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      tmr_q        <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tmr_q        <= tmr_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
`ifdef DESER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  // ack marks the handshake cycle itself, so it follows out_ready directly.
  assign ack        = data_valid_q & out_ready;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;
`ifdef DESER_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/deser_ctrl.md
DESER_CTRL -- requirements
Module: deser_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8: bits per word, range 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 40: maximum clock_1M cycles allowed between bit_tick pulses while shifting; minimum 2.
REQ-003 SHALL have port clock_1M  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; 0 resets the block.
REQ-005 SHALL have port data_in  input  1  serial data bit, sampled only on bit_tick.
REQ-006 SHALL have port bit_tick  input  1  one-cycle sample strobe, nominal 100 kHz rate (every 10 clock_1M cycles).
REQ-007 SHALL have port frame_start  input  1  one-cycle request to begin receiving a word.
REQ-008 SHALL have port out_ready  input  1  downstream is able to accept data_out.
REQ-009 SHALL have port data_out  output  WORD_W  assembled word, MSB received first.
REQ-010 SHALL have port data_valid  output  1  data_out holds a complete word.
REQ-011 SHALL have port ack  output  1  one-cycle pulse on the cycle a word is handed off.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port overrun  output  1  sticky error flag: a bit_tick was lost while a word was held.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse when a frame is aborted because bit_tick stopped.

Function
REQ-015 SHALL implement the states IDLE, SHIFT and HOLD, plus PARITY when PARITY_EN is defined.
REQ-016 In IDLE, frame_start=1 SHALL clear the bit counter and timeout counter and move to SHIFT on the next edge; a bit_tick in the same cycle SHALL NOT be sampled.
REQ-017 In SHIFT, each bit_tick SHALL shift data_in into the LSB of the shift register and increment the bit counter.
REQ-018 On the WORD_W-th bit_tick, SHALL load data_out and set data_valid on the next edge (latency 1 cycle after the final tick), then enter HOLD.
REQ-019 In HOLD, data_valid=1 and out_ready=1 SHALL complete the handshake: ack=1 for exactly that cycle, data_valid cleared on the next edge, return to IDLE.
REQ-020 data_out SHALL stay stable while data_valid=1 and SHALL keep its last value after the handshake.
REQ-021 A bit_tick received while in HOLD SHALL set overrun=1; overrun SHALL stay high until reset.
REQ-022 frame_start SHALL be ignored in SHIFT, HOLD and PARITY.
REQ-023 In SHIFT, the timeout counter SHALL restart on every bit_tick; once TIMEOUT_CYC cycles pass without a tick, the block SHALL pulse timeout for one cycle, discard the partial word and return to IDLE; data_valid SHALL stay 0.
REQ-024 busy SHALL be a registered output equal to (state != IDLE).

Reset
REQ-025 When reset=0, at any time (including mid-frame), the block SHALL immediately enter IDLE and clear: data_out=0, data_valid=0, ack=0, busy=0, overrun=0, timeout=0, and the shift register and all counters.
REQ-026 After reset is released, the first active state change SHALL occur no earlier than the first rising edge of clock_1M with reset=1.

Configuration
REQ-027 When macro DESER_PARITY_EN is defined, SHALL enter PARITY after the WORD_W-th tick. The next bit_tick SHALL sample the even-parity bit, and a parity_err output (1 bit) SHALL be valid together with data_valid. The timeout rule also applies in PARITY.
REQ-028 When DESER_PARITY_EN is not defined, the PARITY state and the parity_err port SHALL NOT exist, and HOLD SHALL follow directly after the WORD_W-th tick.

Verification
REQ-029 Reset held low for 2 cycles, then released: all outputs 0, busy=0.
REQ-030 frame_start, then 8 ticks every 10 cycles with bits 1,0,1,1,0,0,1,0 and out_ready=1: data_out=8'hB2, data_valid=1 one cycle after the 8th tick, ack pulses once, busy falls.
REQ-031 Word 8'h5A completed with out_ready=0, extra bit_tick issued, out_ready raised 30 cycles later: data_out stays 8'h5A throughout, overrun=1 and stays 1 after the handshake.
REQ-032 frame_start, 3 ticks, then no ticks: timeout pulse exactly 40 cycles after the 3rd tick, state IDLE, data_valid never 1.
REQ-033 reset pulled low after the 5th tick of a frame: all outputs 0 immediately; a following full frame 8'hFF is received correctly.
REQ-034 With DESER_PARITY_EN: 8'hB2 followed by parity bit 0 gives parity_err=0; the same word with parity bit 1 gives parity_err=1, both valid together with data_valid.
